// File: rtl/rbcp_pkg.sv
// rbcp_pkg: shared offset map and FSM encoding for RBCP register slaves
package rbcp_pkg;
  localparam logic [5:0] OFS_CTRL = 6'h00;
  localparam logic [5:0] OFS_STAT = 6'h10;
  localparam logic [5:0] OFS_CMD  = 6'h20;
  localparam logic [5:0] OFS_ERR  = 6'h22;
  localparam logic [5:0] OFS_VER  = 6'h30;
  typedef enum logic {IDLE, RESP} state_t;
endpackage

// File: rtl/rbcp_reg_bank_if.sv
// rbcp_reg_bank_if: SiTCP RBCP local bus between the core (master) and a register slave
interface rbcp_reg_bank_if;
  logic        RBCP_ACT;
  logic [31:0] RBCP_ADDR;
  logic        RBCP_WE;
  logic [7:0]  RBCP_WD;
  logic        RBCP_RE;
  logic        RBCP_ACK;
  logic [7:0]  RBCP_RD;
  modport master (output RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_WD, RBCP_RE, input RBCP_ACK, RBCP_RD);
  modport slave (input RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_WD, RBCP_RE, output RBCP_ACK, RBCP_RD);
endinterface

// File: rtl/rbcp_addr_decode.sv
// rbcp_addr_decode: classifies an RBCP byte address into the register bank's regions
module rbcp_addr_decode
  import rbcp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int NUM_CTRL = 8,
  parameter int NUM_STAT = 4
) (
  input  logic [31:0] addr,
  output logic        is_ctrl,
  output logic        is_stat,
  output logic        is_cmd,
  output logic        is_err,
  output logic        is_ver,
  output logic [3:0]  index
);
  logic       hit;
  logic [5:0] ofs;
  assign hit     = addr[31:6] == BASE_ADDR[31:6];
  assign ofs     = addr[5:0];
  assign index   = ofs[3:0];
  // Only the low NUM_* slots of each 16-byte window exist; the rest decode as unmapped
  assign is_ctrl = hit && ofs[5:4] == OFS_CTRL[5:4] && {1'b0, ofs[3:0]} < 5'(NUM_CTRL);
  assign is_stat = hit && ofs[5:4] == OFS_STAT[5:4] && {1'b0, ofs[3:0]} < 5'(NUM_STAT);
  assign is_cmd  = hit && ofs == OFS_CMD;
  assign is_err  = hit && ofs == OFS_ERR;
  assign is_ver  = hit && ofs == OFS_VER;
endmodule

// File: rtl/rbcp_reg_bank.sv
// rbcp_reg_bank: RBCP register slave with control, status, command-pulse and error-count registers
module rbcp_reg_bank
  import rbcp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int NUM_CTRL = 8,
  parameter int NUM_STAT = 4,
  parameter logic [8*NUM_CTRL-1:0] CTRL_INIT = '0,
  parameter logic [7:0] VERSION = 8'h01
) (
  input  logic                  CLK,
  input  logic                  RST,
  rbcp_reg_bank_if.slave        bus,
  output logic [8*NUM_CTRL-1:0] CTRL_OUT,
  input  logic [8*NUM_STAT-1:0] STAT_IN,
  output logic [7:0]            CMD_PULSE
);
  state_t     state, state_n;
  logic       is_ctrl, is_stat, is_cmd, is_err, is_ver;
  logic [3:0] idx;
  logic       strobe, mapped, acc, wr;
  logic [7:0] rdata, rd_q, err_cnt;
  logic [7:0] ctrl_rd [16];
  logic [7:0] stat_rd [16];
  rbcp_addr_decode #(.BASE_ADDR(BASE_ADDR), .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT)) u_dec (
    .addr(bus.RBCP_ADDR), .is_ctrl(is_ctrl), .is_stat(is_stat), .is_cmd(is_cmd),
    .is_err(is_err), .is_ver(is_ver), .index(idx)
  );
  assign strobe = bus.RBCP_ACT && (bus.RBCP_WE || bus.RBCP_RE) && state == IDLE;
  assign mapped = is_ctrl || is_stat || is_cmd || is_err || is_ver;
  assign acc    = strobe && mapped;
  assign wr     = acc && bus.RBCP_WE;
  genvar i;
  for (i = 0; i < 16; i++) begin : g_reg
    if (i < NUM_CTRL) begin : g_ctrl
      logic [7:0] r;
      always_ff @(posedge CLK or posedge RST)
        if (RST) r <= CTRL_INIT[8*i +: 8];
        else if (wr && is_ctrl && idx == 4'(i)) r <= bus.RBCP_WD;
      assign ctrl_rd[i]        = r;
      assign CTRL_OUT[8*i +: 8] = r;
    end else begin : g_ctrl_none
      assign ctrl_rd[i] = 8'h00;
    end
    if (i < NUM_STAT) begin : g_stat
      assign stat_rd[i] = STAT_IN[8*i +: 8];
    end else begin : g_stat_none
      assign stat_rd[i] = 8'h00;
    end
  end
  always_comb rdata = is_ctrl ? ctrl_rd[idx] : is_stat ? stat_rd[idx] : is_err ? err_cnt :
                      is_ver ? VERSION : 8'h00;
  always_comb state_n = (state == IDLE && acc) ? RESP : IDLE;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_n;
  // Read data is captured at the strobe edge and self-clears, so RD is nonzero only while ACK is high
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rd_q      <= 8'h00;
      CMD_PULSE <= 8'h00;
      err_cnt   <= 8'h00;
    end else begin
      rd_q      <= (acc && !bus.RBCP_WE) ? rdata : 8'h00;
      CMD_PULSE <= (wr && is_cmd) ? bus.RBCP_WD : 8'h00;
      if (strobe && !mapped && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
    end
  assign bus.RBCP_ACK = state == RESP;
  assign bus.RBCP_RD  = rd_q;
endmodule

// File: doc/rbcp_reg_bank.md
Name: rbcp_reg_bank

Overview:
- Register-slave bank sitting directly downstream of the SiTCP core's RBCP (UDP) local bus; consumes ACT/ADDR/WE/WD/RE and returns ACK/RD.
- Provides host-writable control registers, sampled read-only status inputs, a self-clearing command-pulse register and a saturating decode-error counter.
- Runs on the SiTCP user clock (125 MHz).

Parameters:
- BASE_ADDR, 32'h0000_0000, bank base address; must be 64-byte aligned (BASE_ADDR[5:0]==0).
- NUM_CTRL, 8, number of R/W control registers, range 1..16.
- NUM_STAT, 4, number of read-only status registers, range 1..16.
- CTRL_INIT, {8*NUM_CTRL{1'b0}}, reset value of the control bus.
- VERSION, 8'h01, constant returned at offset 0x30.

Ports:
- CLK  in  1  user clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- RBCP_ACT  in  1  RBCP transaction active.
- RBCP_ADDR  in  32  byte address.
- RBCP_WE  in  1  write strobe, single cycle.
- RBCP_WD  in  8  write data.
- RBCP_RE  in  1  read strobe, single cycle.
- RBCP_ACK  out  1  access acknowledge, single-cycle pulse.
- RBCP_RD  out  8  read data, valid only with ACK.
- CTRL_OUT  out  8*NUM_CTRL  control registers, reg i at [8i+7:8i].
- STAT_IN  in  8*NUM_STAT  status inputs, already synchronous to CLK.
- CMD_PULSE  out  8  one-cycle command pulses.

Behaviour:
- Reset values: RBCP_ACK=0, RBCP_RD=0, CTRL_OUT=CTRL_INIT, CMD_PULSE=0, err_cnt=0, FSM=IDLE.
- Address hit: ADDR[31:6]==BASE_ADDR[31:6]. Offset = ADDR[5:0].
- Offset map:
  - 0x00..NUM_CTRL-1: R/W control.
  - 0x10..0x10+NUM_STAT-1: RO status.
  - 0x20: CMD, write-only; reads return 0x00.
  - 0x22: err_cnt, RO.
  - 0x30: VERSION, RO.
  - All other offsets, and any non-hit address, are unmapped.
- A strobe is accepted only when RBCP_ACT=1 and FSM=IDLE. Strobes with ACT=0 are ignored: no ACK, no state change.
- FSM states:
  - IDLE: on an accepted strobe to a mapped offset, go to RESP.
  - RESP: lasts exactly one cycle, then IDLE.
- Latency: strobe in cycle N, ACK=1 in cycle N+1 for exactly one cycle.
- Writes:
  - The control register updates at the end of cycle N and is visible on CTRL_OUT from N+1.
  - A write to RO offsets 0x10–0x30 is acknowledged and the data discarded.
- Reads: STAT_IN is sampled at the N edge. RBCP_RD holds the value during the ACK cycle and is 0x00 in every other cycle.
- CMD write: CMD_PULSE = WD for cycle N+1 only, then 0. Bits written as 0 produce no pulse.
- Unmapped access (WE or RE):
  - No ACK, so SiTCP times out and reports a bus error to the host.
  - err_cnt increments, saturating at 0xFF. FSM stays IDLE.
- WE and RE both high in the same cycle: treated as a write. A single ACK is returned, with RD=0x00.
- A strobe arriving while in RESP is ignored and does not count as an error; SiTCP never issues one, so this is a protocol violation.
- ACT falling during RESP: the ACK still completes.
- Reset asserted mid-transaction: all state clears immediately and the pending ACK is dropped.
- Address arithmetic: no wrap. An offset ≥ NUM_CTRL inside 0x00–0x0F is unmapped.

Decomposition:
- Package rbcp_pkg holds:
  - offset constants OFS_CTRL=6'h00, OFS_STAT=6'h10, OFS_CMD=6'h20, OFS_ERR=6'h22, OFS_VER=6'h30;
  - the FSM state encoding (IDLE, RESP).
- Sub-module rbcp_addr_decode is combinational: hit/offset to {is_ctrl, is_stat, is_cmd, is_err, is_ver, index}. It is reusable by future RBCP slaves.
- The top level holds the FSM, register array, pulse logic and counter.

Test Plan:
- Write 0xA5 to BASE+0x03, then read BASE+0x03 -> ACK one cycle after each strobe; CTRL_OUT[31:24]=0xA5 from N+1; read returns RD=0xA5.
- Set STAT_IN reg1=0x3C and read BASE+0x11; read BASE+0x30 -> RD=0x3C then RD=0x01; RD=0x00 outside the ACK cycles.
- Write 0x81 to BASE+0x20 -> CMD_PULSE=0x81 for exactly one cycle, then 0x00; a read of 0x20 returns 0x00 with ACK.
- Read BASE+0x08 (NUM_CTRL=8) and write BASE+0x40 -> no ACK on either; reading 0x22 returns 0x02. Issue 300 unmapped strobes -> err_cnt reads 0xFF.
- WE and RE high together on BASE+0x00 with WD=0x5A -> one ACK, RD=0x00, CTRL_OUT[7:0]=0x5A. A strobe with ACT=0 -> no ACK, no change.
- Assert RST in the cycle after a write strobe -> ACK stays 0; CTRL_OUT returns to CTRL_INIT and err_cnt to 0 asynchronously.
